// File: rtl/reg_bank_param.sv
// Parametrised register bank: two registered write-first read ports, byte-enabled write port,
// optional PC slot refreshed every cycle, and a one-register-per-cycle clear sweep.
module reg_bank_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int PC_IDX   = 14,
    parameter bit PC_EN    = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ADDR_W-1:0]   ra1_i,
    input  logic [ADDR_W-1:0]   ra2_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   wa_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] wbe_i,
    input  logic [DATA_W-1:0]   wd_i,
    input  logic [DATA_W-1:0]   pc_in_i,
    input  logic                clr_req_i,
    output logic [DATA_W-1:0]   rd1_o,
    output logic [DATA_W-1:0]   rd2_o,
    output logic                busy_o,
    output logic                clr_done_o
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PcAddr  = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StSweep = 1'b1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              busy;

    assign busy = (state_q == StSweep);

    // regs_d doubles as the write-first bypass: it already holds the merged post-edge word.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (!busy) begin
            if (PC_EN) begin
                regs_d[PcAddr] = pc_in_i;
            end
            if (we_i) begin
                for (int b = 0; b < NB; b++) begin
                    if (wbe_i[b]) begin
                        regs_d[wa_i][8*b +: 8] = wd_i[8*b +: 8];
                    end
                end
            end
        end else begin
            regs_d[cnt_q] = '0;
        end
    end

    // During the sweep reads see current storage only, with no bypass.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (re_i) begin
            rd1_d = busy ? regs_q[ra1_i] : regs_d[ra1_i];
            rd2_d = busy ? regs_q[ra2_i] : regs_d[ra2_i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (clr_req_i) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rd1_q   <= '0;
            rd2_q   <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign rd1_o      = rd1_q;
    assign rd2_o      = rd2_q;
    assign busy_o     = busy;
    assign clr_done_o = done_q;

endmodule

// File: tb/tb_reg_bank_param.sv
// Bench for reg_bank_param: two instances (PC_EN=0 and PC_EN=1) driven in lockstep and compared
// every cycle against a behavioural model, plus directed literal expectations.
module tb_reg_bank_param;

    localparam int NR  = 16;
    localparam int PCI = 14;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  ra1_i, ra2_i, wa_i, wbe_i;
    logic        re_i, we_i, clr_req_i;
    logic [31:0] wd_i, pc_in_i;

    logic [31:0] p0_rd1, p0_rd2, p1_rd1, p1_rd2;
    logic        p0_busy, p1_busy, p0_done, p1_done;

    int checks   = 0;
    int failures = 0;

    // Model state; index 0 = PC_EN=0 instance, index 1 = PC_EN=1 instance.
    logic [31:0] mem [2][NR];
    logic [31:0] mrd1 [2];
    logic [31:0] mrd2 [2];
    logic        mbusy, mdone;
    int          mcnt;

    always #5 clk_i = ~clk_i;

    reg_bank_param #(.DATA_W(32), .NUM_REGS(16), .PC_IDX(14), .PC_EN(1'b0)) u_pc0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .ra1_i(ra1_i), .ra2_i(ra2_i), .re_i(re_i),
        .wa_i(wa_i), .we_i(we_i), .wbe_i(wbe_i), .wd_i(wd_i), .pc_in_i(pc_in_i),
        .clr_req_i(clr_req_i), .rd1_o(p0_rd1), .rd2_o(p0_rd2), .busy_o(p0_busy),
        .clr_done_o(p0_done)
    );

    reg_bank_param #(.DATA_W(32), .NUM_REGS(16), .PC_IDX(14), .PC_EN(1'b1)) u_pc1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .ra1_i(ra1_i), .ra2_i(ra2_i), .re_i(re_i),
        .wa_i(wa_i), .we_i(we_i), .wbe_i(wbe_i), .wd_i(wd_i), .pc_in_i(pc_in_i),
        .clr_req_i(clr_req_i), .rd1_o(p1_rd1), .rd2_o(p1_rd2), .busy_o(p1_busy),
        .clr_done_o(p1_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NR; i++) mem[k][i] = '0;
            mrd1[k] = '0;
            mrd2[k] = '0;
        end
        mbusy = 1'b0;
        mdone = 1'b0;
        mcnt  = 0;
    endtask

    // One clock edge of the behavioural model, from the currently driven inputs.
    task automatic model_step();
        logic [31:0] nm [NR];
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NR; i++) nm[i] = mem[k][i];
            if (!mbusy) begin
                if (k == 1) nm[PCI] = pc_in_i;
                if (we_i) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wbe_i[b]) nm[wa_i][8*b +: 8] = wd_i[8*b +: 8];
                    end
                end
            end else begin
                nm[mcnt] = '0;
            end
            if (re_i) begin
                mrd1[k] = mbusy ? mem[k][ra1_i] : nm[ra1_i];
                mrd2[k] = mbusy ? mem[k][ra2_i] : nm[ra2_i];
            end
            for (int i = 0; i < NR; i++) mem[k][i] = nm[i];
        end
        mdone = 1'b0;
        if (mbusy) begin
            if (mcnt == NR - 1) begin
                mbusy = 1'b0;
                mdone = 1'b1;
            end else begin
                mcnt++;
            end
        end else if (clr_req_i) begin
            mbusy = 1'b1;
            mcnt  = 0;
        end
    endtask

    task automatic check_all();
        chk("rd1_pc0", p0_rd1, mrd1[0]);
        chk("rd2_pc0", p0_rd2, mrd2[0]);
        chk("rd1_pc1", p1_rd1, mrd1[1]);
        chk("rd2_pc1", p1_rd2, mrd2[1]);
        chk("busy_pc0", {31'b0, p0_busy}, {31'b0, mbusy});
        chk("busy_pc1", {31'b0, p1_busy}, {31'b0, mbusy});
        chk("done_pc0", {31'b0, p0_done}, {31'b0, mdone});
        chk("done_pc1", {31'b0, p1_done}, {31'b0, mdone});
    endtask

    // Called at posedge+1; returns at the following posedge+1 after comparing.
    task automatic cycle();
        model_step();
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        we_i = 1'b0; re_i = 1'b0; clr_req_i = 1'b0;
        wbe_i = 4'h0; wd_i = '0; wa_i = '0; ra1_i = '0; ra2_i = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        set_idle();
        we_i = 1'b1; wa_i = a; wd_i = d; wbe_i = be;
        cycle();
        set_idle();
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
        set_idle();
        re_i = 1'b1; ra1_i = a1; ra2_i = a2;
        cycle();
        set_idle();
    endtask

    // Asserts reset mid-cycle, checks outputs cleared at once, releases mid-cycle.
    task automatic do_reset();
        #3 rst_ni = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset_rd1_now", p1_rd1, 32'h0);
        chk("reset_busy_now", {31'b0, p1_busy}, 32'h0);
        @(posedge clk_i);
        #1;
        check_all();
        #3 rst_ni = 1'b1;
    endtask

    int busy_cnt, done_cnt;

    initial begin
        rst_ni  = 1'b0;
        pc_in_i = '0;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all();
        rst_ni = 1'b1;

        // Reset clears a written register.
        wr(4'd3, 32'hDEADBEEF, 4'hF);
        rd(4'd3, 4'd3);
        chk("r3_written", p1_rd1, 32'hDEADBEEF);
        do_reset();
        rd(4'd3, 4'd3);
        chk("r3_after_reset_pc1", p1_rd1, 32'h0);
        chk("r3_after_reset_pc0", p0_rd2, 32'h0);

        // Write then read, then byte-enabled merge.
        wr(4'd5, 32'h12345678, 4'hF);
        rd(4'd5, 4'd0);
        chk("r5_full", p1_rd1, 32'h12345678);
        wr(4'd5, 32'hAABBCCDD, 4'b0101);
        rd(4'd5, 4'd5);
        chk("r5_bytes", p0_rd2, 32'h12BB56DD);

        // Same-cycle bypass on both ports, then hold with re=0.
        set_idle();
        we_i = 1'b1; wa_i = 4'd7; wd_i = 32'hCAFEF00D; wbe_i = 4'hF;
        re_i = 1'b1; ra1_i = 4'd7; ra2_i = 4'd7;
        cycle();
        chk("bypass_rd1", p1_rd1, 32'hCAFEF00D);
        chk("bypass_rd2", p1_rd2, 32'hCAFEF00D);
        set_idle();
        ra2_i = 4'd3;
        cycle();
        chk("hold_rd1", p1_rd1, 32'hCAFEF00D);
        chk("hold_rd2", p0_rd2, 32'hCAFEF00D);

        // PC slot.
        pc_in_i = 32'h100;
        rd(4'd14, 4'd14);
        chk("pc_read", p1_rd1, 32'h100);
        wr(4'd14, 32'hA5A5A5A5, 4'hF);
        set_idle();
        we_i = 1'b1; wa_i = 4'd14; wd_i = 32'h200; wbe_i = 4'b0011;
        pc_in_i = 32'h00FF0300; re_i = 1'b1; ra1_i = 4'd14;
        cycle();
        chk("pc_merge_pc1", p1_rd1, 32'h00FF0200);
        chk("pc_merge_pc0", p0_rd1, 32'hA5A50200);
        pc_in_i = 32'h55;
        rd(4'd14, 4'd14);
        chk("pc_off_holds", p0_rd1, 32'hA5A50200);
        chk("pc_on_refresh", p1_rd1, 32'h55);

        // Full sweep with dropped writes and a mid-sweep read.
        pc_in_i = 32'hEEEEEEEE;
        for (int i = 0; i < NR; i++) wr(4'(i), 32'h11111111 * i, 4'hF);
        set_idle();
        clr_req_i = 1'b1;
        cycle();
        chk("busy_rise", {31'b0, p1_busy}, 32'h1);
        busy_cnt = p1_busy ? 1 : 0;
        done_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            set_idle();
            we_i = 1'b1; wa_i = 4'd15; wd_i = 32'h0BADF00D; wbe_i = 4'hF;
            re_i = (j == 3); ra1_i = 4'd15;
            clr_req_i = (j == 5);
            cycle();
            if (j == 3) chk("r15_mid_sweep", p0_rd1, 32'hFFFFFFFF);
            if (p1_busy) busy_cnt++;
            if (p1_done) done_cnt++;
            if (j == 15) break;
        end
        set_idle();
        cycle();
        if (p1_busy) busy_cnt++;
        if (p1_done) done_cnt++;
        chk("busy_cycles", busy_cnt, 32'd16);
        chk("done_pulses", done_cnt, 32'd1);
        pc_in_i = 32'h0;
        for (int i = 0; i < NR; i++) begin
            rd(4'(i), 4'(i));
            chk("cleared_pc0", p0_rd1, 32'h0);
            chk("cleared_pc1", p1_rd2, 32'h0);
        end

        // Reset in the middle of a sweep.
        wr(4'd2, 32'h22222222, 4'hF);
        set_idle();
        clr_req_i = 1'b1;
        cycle();
        set_idle();
        repeat (8) cycle();
        chk("busy_before_reset", {31'b0, p0_busy}, 32'h1);
        do_reset();
        chk("busy_after_reset", {31'b0, p0_busy}, 32'h0);
        done_cnt = 0;
        set_idle();
        for (int j = 0; j < 20; j++) begin
            cycle();
            if (p0_done || p1_done) done_cnt++;
        end
        chk("no_done_after_reset", done_cnt, 32'd0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            ra1_i     = 4'($urandom_range(0, 15));
            ra2_i     = 4'($urandom_range(0, 15));
            wa_i      = 4'($urandom_range(0, 15));
            re_i      = ($urandom_range(0, 3) != 0);
            we_i      = ($urandom_range(0, 1) != 0);
            wbe_i     = 4'($urandom_range(0, 15));
            wd_i      = $urandom;
            pc_in_i   = $urandom;
            clr_req_i = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
